// File: rtl/hebbian_writer_if.sv
// ============================================================================
// hebbian_writer_if
// Training handshake plus weight-memory port bundle for hebbian_writer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface hebbian_writer_if #(
  parameter int N  = 25,
  parameter int WW = 4,
  parameter int AW = 10
);
  logic          clr;
  logic          pat_valid;
  logic [N-1:0]  pat;
  logic          pat_ready;
  logic          w_re;
  logic [AW-1:0] w_raddr;
  logic [WW-1:0] w_rdata;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [WW-1:0] w_wdata;
  logic          busy;
  logic          done;
  logic [7:0]    npat;

  // Trainer side
  modport slave (
    input  clr, pat_valid, pat, w_rdata,
    output pat_ready, w_re, w_raddr, w_we, w_waddr, w_wdata, busy, done, npat
  );

  // Pattern source / weight-memory side
  modport master (
    output clr, pat_valid, pat, w_rdata,
    input  pat_ready, w_re, w_raddr, w_we, w_waddr, w_wdata, busy, done, npat
  );
endinterface

`default_nettype wire

// File: rtl/hebbian_writer.sv
// ============================================================================
// hebbian_writer
// Sequential Hebbian trainer for an N x N Hopfield weight memory. Each
// accepted pattern walks all entries with a 1-cycle-deep read-modify-write
// (+1 where bits agree, -1 where they differ); a clear command zeroes memory.
// Optional macro HEBB_SAT_EN: saturate written weights instead of wrapping.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hebbian_writer #(
  parameter int N  = 25,
  parameter int WW = 4,
  parameter int AW = 10
) (
  input  wire logic        clk_i,
  input  wire logic        rst_ni,
  hebbian_writer_if.slave  bus
);

  localparam int            KW        = (N > 1) ? $clog2(N) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(N * N - 1);
  localparam logic [KW-1:0] LAST_IDX  = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  state_t        state_q;
  logic          ready_q;
  logic          re_q;
  logic          we_q;
  logic          busy_q;
  logic          done_q;
  logic          inc_q;   // delta for the entry being written: 1 -> +1, 0 -> -1
  logic [AW-1:0] raddr_q;
  logic [AW-1:0] waddr_q;
  logic [KW-1:0] k_q;
  logic [KW-1:0] m_q;
  logic [N-1:0]  pat_q;
  logic [7:0]    npat_q;

  logic [WW:0]   sum;
  logic [WW-1:0] wval;

  // Sign-extend to WW+1 bits so the +/-1 step cannot overflow, then reduce.
  always_comb begin
    sum  = {bus.w_rdata[WW-1], bus.w_rdata} + (inc_q ? (WW+1)'(1) : {(WW+1){1'b1}});
    wval = sum[WW-1:0];
`ifdef HEBB_SAT_EN
    if (sum[WW] != sum[WW-1]) begin
      wval = {sum[WW], {(WW-1){~sum[WW]}}};
    end
`else
    wval = sum[WW-1:0];
`endif
  end

  assign bus.pat_ready = ready_q & ~bus.clr;
  assign bus.w_re      = re_q;
  assign bus.w_raddr   = raddr_q;
  assign bus.w_we      = we_q;
  assign bus.w_waddr   = waddr_q;
  // Write data is only non-zero for update writes; clear writes zeros.
  assign bus.w_wdata   = (we_q && (state_q == UPDATE)) ? wval : '0;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.npat      = npat_q;

  // Control FSM: address generation, counters and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      inc_q   <= 1'b0;
      raddr_q <= '0;
      waddr_q <= '0;
      k_q     <= '0;
      m_q     <= '0;
      pat_q   <= '0;
      npat_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // clr has priority; the pattern stays pending on the bus.
          if (bus.clr) begin
            state_q <= CLEAR;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            we_q    <= 1'b1;
            waddr_q <= '0;
          end else if (bus.pat_valid) begin
            state_q <= UPDATE;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            pat_q   <= bus.pat;
            re_q    <= 1'b1;
            raddr_q <= '0;
            k_q     <= '0;
            m_q     <= '0;
          end
        end
        CLEAR: begin
          if (waddr_q == LAST_ADDR) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            waddr_q <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            npat_q  <= '0;
          end else begin
            waddr_q <= waddr_q + 1'b1;
          end
        end
        UPDATE: begin
          if (re_q) begin
            // Entry read this cycle is written next cycle, with its delta.
            we_q    <= 1'b1;
            waddr_q <= raddr_q;
            inc_q   <= (pat_q[k_q] == pat_q[m_q]);
            if (raddr_q == LAST_ADDR) begin
              re_q    <= 1'b0;
              raddr_q <= '0;
            end else begin
              raddr_q <= raddr_q + 1'b1;
              if (m_q == LAST_IDX) begin
                m_q <= '0;
                k_q <= k_q + 1'b1;
              end else begin
                m_q <= m_q + 1'b1;
              end
            end
          end else begin
            // Final write has just completed.
            state_q <= IDLE;
            we_q    <= 1'b0;
            waddr_q <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            if (npat_q != 8'hFF) begin
              npat_q <= npat_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hebbian_writer.sv
// ============================================================================
// tb_hebbian_writer
// Directed bench for hebbian_writer with a synchronous weight-memory model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hebbian_writer;

  localparam int N  = 25;
  localparam int WW = 4;
  localparam int AW = 10;
  localparam int NN = N * N;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  hebbian_writer_if #(.N(N), .WW(WW), .AW(AW)) hif ();

  hebbian_writer #(.N(N), .WW(WW), .AW(AW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (hif)
  );

  // Weight memory: synchronous read, 1-cycle latency.
  logic signed [WW-1:0] mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (hif.w_re) hif.w_rdata <= mem[hif.w_raddr];
    if (hif.w_we) mem[hif.w_waddr] <= hif.w_wdata;
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Follows one operation cycle by cycle from cycle 0; stops at done.
  task automatic watch(input bit upd, output int done_cyc, output int nwr,
                       output int bad);
    logic [AW-1:0] ea;
    done_cyc = -1;
    nwr      = 0;
    bad      = 0;
    for (int c = 0; c < NN + 20; c++) begin
      @(negedge clk);
      if (hif.w_we === 1'b1) nwr++;
      if (upd) begin
        ea = (c < NN) ? AW'(c) : '0;
        if (hif.w_re !== (c < NN)) bad++;
        if (hif.w_raddr !== ea) bad++;
        ea = (c >= 1 && c <= NN) ? AW'(c - 1) : '0;
        if (hif.w_we !== (c >= 1 && c <= NN)) bad++;
        if (hif.w_waddr !== ea) bad++;
        if (hif.w_we !== 1'b1 && hif.w_wdata !== '0) bad++;
        if (hif.busy !== (c <= NN)) bad++;
      end else begin
        ea = (c < NN) ? AW'(c) : '0;
        if (hif.w_re !== 1'b0) bad++;
        if (hif.w_we !== (c < NN)) bad++;
        if (hif.w_waddr !== ea) bad++;
        if (hif.w_wdata !== '0) bad++;
        if (hif.busy !== (c < NN)) bad++;
      end
      if (hif.done === 1'b1) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  task automatic do_clear(input string tag);
    int dc, nw, bd;
    @(negedge clk);
    hif.clr = 1'b1;
    @(posedge clk);
    #1 hif.clr = 1'b0;
    watch(1'b0, dc, nw, bd);
    check({tag, " clear done cycle"}, dc, NN);
    check({tag, " clear writes"}, nw, NN);
    check({tag, " clear sequence errors"}, bd, 0);
    check({tag, " clear npat"}, hif.npat, 0);
  endtask

  task automatic do_pat(input logic [N-1:0] p, input string tag);
    int dc, nw, bd;
    @(negedge clk);
    hif.pat       = p;
    hif.pat_valid = 1'b1;
    @(posedge clk);
    #1 hif.pat_valid = 1'b0;
    watch(1'b1, dc, nw, bd);
    check({tag, " done cycle"}, dc, NN + 1);
    check({tag, " writes"}, nw, NN);
    check({tag, " sequence errors"}, bd, 0);
  endtask

  initial begin
    int dc, nw, bd, cnt;
    hif.clr       = 1'b0;
    hif.pat_valid = 1'b0;
    hif.pat       = '0;

    // Reset and release
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset pat_ready", hif.pat_ready, 1);
    check("reset w_re", hif.w_re, 0);
    check("reset w_we", hif.w_we, 0);
    check("reset w_raddr", hif.w_raddr, 0);
    check("reset w_waddr", hif.w_waddr, 0);
    check("reset w_wdata", hif.w_wdata, 0);
    check("reset busy", hif.busy, 0);
    check("reset done", hif.done, 0);
    check("reset npat", hif.npat, 0);

    // Clear
    do_clear("c1");
    check("c1 mem0", mem[0], 0);
    check("c1 mem624", mem[624], 0);

    // All-ones pattern: every entry becomes +1
    do_pat(25'h1FFFFFF, "ones1");
    check("ones1 npat", hif.npat, 1);
    cnt = 0;
    for (int a = 0; a < NN; a++) if (mem[a] !== 4'sd1) cnt++;
    check("ones1 entries not +1", cnt, 0);

    // pat_valid held: second pattern accepted exactly at cycle 626
    @(negedge clk);
    hif.pat       = 25'h1FFFFFF;
    hif.pat_valid = 1'b1;
    @(posedge clk);
    watch(1'b1, dc, nw, bd);
    check("held first done cycle", dc, NN + 1);
    check("held first errors", bd, 0);
    check("held pat_ready at done", hif.pat_ready, 1);
    @(posedge clk);
    #1 hif.pat_valid = 1'b0;
    watch(1'b1, dc, nw, bd);
    check("held second done cycle", dc, NN + 1);
    check("held second errors", bd, 0);
    check("held npat", hif.npat, 3);
    check("held mem1", mem[1], 3);

    // Accumulate to the weight limit
    for (int i = 0; i < 4; i++) do_pat(25'h1FFFFFF, "ones");
    check("seven mem1", mem[1], 7);
    check("seven mem0", mem[0], 7);
    do_pat(25'h1FFFFFF, "ones8");
`ifdef HEBB_SAT_EN
    check("eight mem1", mem[1], 7);
`else
    check("eight mem1", mem[1], -8);
`endif
    do_pat(25'h1FFFFFF, "ones9");
`ifdef HEBB_SAT_EN
    check("nine mem1", mem[1], 7);
`else
    check("nine mem1", mem[1], -7);
`endif
    check("nine npat", hif.npat, 9);

    // clr and pat_valid together: clear first, pattern after its done
    @(negedge clk);
    hif.pat       = 25'h0000001;
    hif.pat_valid = 1'b1;
    hif.clr       = 1'b1;
    @(posedge clk);
    #1 hif.clr = 1'b0;
    watch(1'b0, dc, nw, bd);
    check("clrpat clear done cycle", dc, NN);
    check("clrpat clear errors", bd, 0);
    check("clrpat pat_ready at done", hif.pat_ready, 1);
    @(posedge clk);
    #1 hif.pat_valid = 1'b0;
    watch(1'b1, dc, nw, bd);
    check("clrpat update done cycle", dc, NN + 1);
    check("clrpat update errors", bd, 0);
    check("clrpat npat", hif.npat, 1);
    check("p1 mem0", mem[0], 1);
    check("p1 mem1", mem[1], -1);
    check("p1 mem25", mem[25], -1);
    check("p1 mem26", mem[26], 1);
    check("p1 mem27", mem[27], 1);
    check("p1 mem624", mem[624], 1);

    // Reset asserted at update cycle 300
    @(negedge clk);
    hif.pat       = 25'h1FFFFFF;
    hif.pat_valid = 1'b1;
    @(posedge clk);
    #1 hif.pat_valid = 1'b0;
    repeat (301) @(negedge clk);
    check("pre-reset w_re", hif.w_re, 1);
    rst_n = 1'b0;
    #1;
    check("midrst w_re", hif.w_re, 0);
    check("midrst w_we", hif.w_we, 0);
    check("midrst w_raddr", hif.w_raddr, 0);
    check("midrst w_waddr", hif.w_waddr, 0);
    check("midrst busy", hif.busy, 0);
    check("midrst npat", hif.npat, 0);
    check("midrst pat_ready", hif.pat_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (hif.w_we !== 1'b0 || hif.w_re !== 1'b0 || hif.busy !== 1'b0) cnt++;
    end
    check("post-reset activity", cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
